// File: rtl/schnorr_core_pkg.sv
// Shared definitions for the Schnorr signature engine:
// mode codes, FSM states, LFSR polynomial and default group.
package schnorr_core_pkg;

    typedef enum logic [1:0] {
        MODE_KEYGEN  = 2'b00,
        MODE_SIGN    = 2'b01,
        MODE_VERIFY  = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DRAWX,
        ST_DRAWR,
        ST_EXP,
        ST_HASH,
        ST_SIGN,
        ST_EXP2,
        ST_MUL,
        ST_CMP,
        ST_FIN
    } state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int DEF_P_MOD = 2039;
    localparam int DEF_Q_ORD = 1019;
    localparam int DEF_GEN   = 4;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/schnorr_core_if.sv
// Operation bus of the Schnorr engine: mode/start/operands in,
// results and completion flags out.
interface schnorr_core_if #(
    parameter int len = 16
);
    logic [1:0]     mode;
    logic           start;
    logic [31:0]    msg;
    logic [len-1:0] P_in;
    logic [len-1:0] s_in;
    logic [len-1:0] R_in;
    logic [len-1:0] P_out;
    logic [len-1:0] s_out;
    logic [len-1:0] R_out;
    logic           valid_gen;
    logic           valid_sign;
    logic           valid_ver;
    logic           done;

    modport master (
        output mode, start, msg, P_in, s_in, R_in,
        input  P_out, s_out, R_out,
        input  valid_gen, valid_sign, valid_ver, done
    );

    modport slave (
        input  mode, start, msg, P_in, s_in, R_in,
        output P_out, s_out, R_out,
        output valid_gen, valid_sign, valid_ver, done
    );
endinterface

// File: rtl/schnorr_core_mod_exp.sv
// Right-to-left square-and-multiply modular exponentiation,
// fixed len+1 cycles per run (load + one exponent bit per cycle).
module mod_exp #(
    parameter int len   = 16,
    parameter int P_MOD = 2039
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [len-1:0] base,
    input  logic [len-1:0] exponent,
    output logic [len-1:0] result,
    output logic           done
);

    localparam int unsigned W2 = 2 * len;
    localparam int unsigned CW = $clog2(len + 1);
    localparam logic [W2-1:0] PW = W2'(P_MOD);
    localparam logic [CW-1:0] LAST = CW'(len - 1);

    logic [len-1:0] b_q;
    logic [len-1:0] acc_q;
    logic [len-1:0] e_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;
    logic [W2-1:0]  sq_w;
    logic [W2-1:0]  mul_w;
    logic [W2-1:0]  base_w;

    // Reduced square, multiply and base for the current step
    always_comb begin
        sq_w   = (W2'(b_q) * W2'(b_q)) % PW;
        mul_w  = (W2'(acc_q) * W2'(b_q)) % PW;
        base_w = W2'(base) % PW;
    end

    // Result is the accumulator after the current bit, so it is
    // already final in the cycle where done is high.
    assign result = e_q[0] ? len'(mul_w) : acc_q;
    assign done   = busy_q && (cnt_q == LAST);

    // Load on start, then consume one exponent bit per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            b_q    <= '0;
            acc_q  <= '0;
            e_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (busy_q) begin
            if (e_q[0]) begin
                acc_q <= len'(mul_w);
            end
            b_q   <= len'(sq_w);
            e_q   <= e_q >> 1;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
            end
        end else if (start) begin
            b_q    <= len'(base_w);
            acc_q  <= len'(1);
            e_q    <= exponent;
            cnt_q  <= '0;
            busy_q <= 1'b1;
        end
    end

endmodule

// File: rtl/schnorr_core.sv
// Schnorr keygen / sign / verify engine over the order-q subgroup
// of Z_p*, sharing a single modular exponentiator.
module schnorr_core
    import schnorr_core_pkg::*;
#(
    parameter int          len   = 16,
    parameter int          P_MOD = DEF_P_MOD,
    parameter int          Q_ORD = DEF_Q_ORD,
    parameter int          GEN   = DEF_GEN,
    parameter logic [31:0] SEED  = 32'h0000_0001
) (
    input logic            clk,
    input logic            rst,
    schnorr_core_if.slave  bus
);

    localparam int unsigned W2 = 2 * len;
    localparam int unsigned W3 = W2 + 1;
    localparam logic [31:0] QM1 = 32'(Q_ORD - 1);

    state_e state_q;
    state_e state_d;
    mode_e  mode_in;
    mode_e  mode_q;

    logic [31:0]    lfsr_q;
    logic [31:0]    msg_q;
    logic [len-1:0] p_in_q;
    logic [len-1:0] s_in_q;
    logic [len-1:0] r_com_q;
    logic [len-1:0] t_q;

    logic [len-1:0] priv_key;
    logic [len-1:0] nonce;
    logic [len-1:0] chall;
    logic [len-1:0] s_right;
    logic [len-1:0] s_left;

    logic [len-1:0] p_out_q;
    logic [len-1:0] s_out_q;
    logic [len-1:0] r_out_q;
    logic           valid_gen_q;
    logic           valid_sign_q;
    logic           valid_ver_q;
    logic           done_q;

    logic           exp_busy_q;
    logic           me_go;
    logic           me_done;
    logic [len-1:0] me_base;
    logic [len-1:0] me_expo;
    logic [len-1:0] me_result;

    logic [len-1:0] draw_val;
    logic [15:0]    h16;
    logic [len-1:0] hash_val;
    logic [W3-1:0]  sgn_wide;
    logic [len-1:0] sign_val;
    logic [W2-1:0]  mul_wide;
    logic [len-1:0] mul_val;

    assign mode_in = mode_e'(bus.mode);

    assign bus.P_out      = p_out_q;
    assign bus.s_out      = s_out_q;
    assign bus.R_out      = r_out_q;
    assign bus.valid_gen  = valid_gen_q;
    assign bus.valid_sign = valid_sign_q;
    assign bus.valid_ver  = valid_ver_q;
    assign bus.done       = done_q;

    // Scalar draws, challenge hash, signature and final product
    always_comb begin
        draw_val = len'((lfsr_q % QM1) + 32'd1);
        h16      = msg_q[31:16] ^ msg_q[15:0] ^ r_com_q[15:0];
        hash_val = len'(32'(h16) % 32'(Q_ORD));
        sgn_wide = W3'(chall) * W3'(priv_key) + W3'(nonce);
        sign_val = len'(sgn_wide % W3'(Q_ORD));
        mul_wide = (W2'(t_q) * W2'(r_com_q)) % W2'(P_MOD);
        mul_val  = len'(mul_wide);
    end

    // Exponentiator operand select: g^x, g^r, g^s, then P^c
    always_comb begin
        me_base = len'(GEN);
        me_expo = priv_key;
        if (state_q == ST_EXP2) begin
            me_base = p_in_q;
            me_expo = chall;
        end else begin
            case (mode_q)
                MODE_SIGN:   me_expo = nonce;
                MODE_VERIFY: me_expo = s_in_q;
                default:     me_expo = priv_key;
            endcase
        end
    end

    assign me_go = ((state_q == ST_EXP) || (state_q == ST_EXP2))
                   && !exp_busy_q;

    mod_exp #(
        .len   (len),
        .P_MOD (P_MOD)
    ) u_mod_exp (
        .clk      (clk),
        .rst      (rst),
        .start    (me_go),
        .base     (me_base),
        .exponent (me_expo),
        .result   (me_result),
        .done     (me_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing for the three operations
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (mode_in)
                        MODE_KEYGEN: state_d = ST_DRAWX;
                        MODE_SIGN:   state_d = ST_DRAWX;
                        MODE_VERIFY: state_d = ST_HASH;
                        default:     state_d = ST_FIN;
                    endcase
                end
            end
            ST_DRAWX: begin
                state_d = (mode_q == MODE_SIGN) ? ST_DRAWR : ST_EXP;
            end
            ST_DRAWR: state_d = ST_EXP;
            ST_EXP: begin
                if (me_done) begin
                    case (mode_q)
                        MODE_SIGN:   state_d = ST_HASH;
                        MODE_VERIFY: state_d = ST_EXP2;
                        default:     state_d = ST_FIN;
                    endcase
                end
            end
            ST_HASH: begin
                state_d = (mode_q == MODE_VERIFY) ? ST_EXP : ST_SIGN;
            end
            ST_SIGN: state_d = ST_FIN;
            ST_EXP2: begin
                if (me_done) begin
                    state_d = ST_MUL;
                end
            end
            ST_MUL:  state_d = ST_CMP;
            ST_CMP:  state_d = ST_FIN;
            ST_FIN:  state_d = ST_FIN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Exponentiator launch tracking: one start pulse per EXP phase
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_busy_q <= 1'b0;
        end else if (me_go) begin
            exp_busy_q <= 1'b1;
        end else if (me_done) begin
            exp_busy_q <= 1'b0;
        end
    end

    // Datapath registers, LFSR and result/flag updates
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q       <= SEED;
            mode_q       <= MODE_KEYGEN;
            msg_q        <= '0;
            p_in_q       <= '0;
            s_in_q       <= '0;
            r_com_q      <= '0;
            t_q          <= '0;
            priv_key     <= '0;
            nonce        <= '0;
            chall        <= '0;
            s_right      <= '0;
            s_left       <= '0;
            p_out_q      <= '0;
            s_out_q      <= '0;
            r_out_q      <= '0;
            valid_gen_q  <= 1'b0;
            valid_sign_q <= 1'b0;
            valid_ver_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_q  <= mode_in;
                        msg_q   <= bus.msg;
                        p_in_q  <= bus.P_in;
                        s_in_q  <= bus.s_in;
                        r_com_q <= bus.R_in;
                        if (mode_in == MODE_ILLEGAL) begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DRAWX: begin
                    priv_key <= draw_val;
                    lfsr_q   <= lfsr_next(lfsr_q);
                end
                ST_DRAWR: begin
                    nonce  <= draw_val;
                    lfsr_q <= lfsr_next(lfsr_q);
                end
                ST_EXP: begin
                    if (me_done) begin
                        case (mode_q)
                            MODE_SIGN:   r_com_q <= me_result;
                            MODE_VERIFY: s_right <= me_result;
                            default: begin
                                p_out_q     <= me_result;
                                valid_gen_q <= 1'b1;
                                done_q      <= 1'b1;
                            end
                        endcase
                    end
                end
                ST_HASH: chall <= hash_val;
                ST_SIGN: begin
                    s_out_q      <= sign_val;
                    r_out_q      <= r_com_q;
                    valid_sign_q <= 1'b1;
                    done_q       <= 1'b1;
                end
                ST_EXP2: begin
                    if (me_done) begin
                        t_q <= me_result;
                    end
                end
                ST_MUL: s_left <= mul_val;
                ST_CMP: begin
                    valid_ver_q <= (s_right == s_left);
                    done_q      <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_schnorr_core.sv
// Self-checking bench for schnorr_core: vector table with a
// result scoreboard, plus reset-abort and held-start sequences.
module tb_schnorr_core;

    localparam int LEN = 16;
    localparam int PM  = 2039;
    localparam int QO  = 1019;
    localparam int G   = 4;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] msg;
        int          p_in;
        int          r_in;
        int          s_in;
        int          e_p;
        int          e_r;
        int          e_s;
        int          e_gen;
        int          e_sign;
        int          e_ver;
        int          e_lat;
        int          e_x;
        int          e_n;
        int          e_c;
        int          e_sr;
        int          e_sl;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    vec_t vecs[6];
    vec_t exp_q[$];

    schnorr_core_if #(.len(LEN)) bus ();

    schnorr_core #(
        .len   (LEN),
        .P_MOD (PM),
        .Q_ORD (QO),
        .GEN   (G),
        .SEED  (32'h0000_0001)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic int modpow(input int b, input int e, input int m);
        int r;
        int bb;
        r  = 1;
        bb = b % m;
        for (int i = 0; i < e; i++) begin
            r = (r * bb) % m;
        end
        return r;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic int draw(input logic [31:0] v);
        return int'(v % 32'd1018) + 1;
    endfunction

    function automatic int hash(input logic [31:0] m, input int r);
        logic [15:0] h;
        h = m[31:16] ^ m[15:0] ^ r[15:0];
        return int'(h) % QO;
    endfunction

    task automatic check(input string name, input longint act,
                         input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input string tag);
        vec_t e;
        int   lat;
        bit   got;
        do_reset();
        bus.mode  = v.mode;
        bus.msg   = v.msg;
        bus.P_in  = v.p_in[15:0];
        bus.R_in  = v.r_in[15:0];
        bus.s_in  = v.s_in[15:0];
        bus.start = 1'b1;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        lat = 1;
        bus.mode = ~v.mode;
        bus.msg  = ~v.msg;
        bus.P_in = ~bus.P_in;
        bus.R_in = ~bus.R_in;
        bus.s_in = ~bus.s_in;
        got = bus.done;
        while (!got && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            got = bus.done;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done not seen in %0d cycles",
                     tag, lat);
        end
        e = exp_q.pop_front();
        check({tag, " latency"}, lat, e.e_lat);
        check({tag, " done"}, bus.done, 1);
        check({tag, " P_out"}, bus.P_out, e.e_p);
        check({tag, " R_out"}, bus.R_out, e.e_r);
        check({tag, " s_out"}, bus.s_out, e.e_s);
        check({tag, " valid_gen"}, bus.valid_gen, e.e_gen);
        check({tag, " valid_sign"}, bus.valid_sign, e.e_sign);
        check({tag, " valid_ver"}, bus.valid_ver, e.e_ver);
        check({tag, " priv_key"}, dut.priv_key, e.e_x);
        check({tag, " nonce"}, dut.nonce, e.e_n);
        check({tag, " chall"}, dut.chall, e.e_c);
        check({tag, " s_right"}, dut.s_right, e.e_sr);
        check({tag, " s_left"}, dut.s_left, e.e_sl);
    endtask

    initial begin
        logic [31:0] l;
        int x;
        int r;
        int rc;
        int c;
        int s;
        int pk;
        logic [31:0] sm;

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        bus.msg   = '0;
        bus.P_in  = '0;
        bus.R_in  = '0;
        bus.s_in  = '0;

        sm = 32'hABCD_EF45;
        l  = 32'h0000_0001;
        x  = draw(l);
        l  = lfsr_step(l);
        r  = draw(l);
        rc = modpow(G, r, PM);
        c  = hash(sm, rc);
        s  = (r + c * x) % QO;
        pk = modpow(G, x, PM);

        vecs[0] = '{2'b00, 32'h0, 0, 0, 0, pk, 0, 0,
                    1, 0, 0, LEN + 3, x, 0, 0, 0, 0};
        vecs[1] = '{2'b01, sm, 0, 0, 0, 0, rc, s,
                    0, 1, 0, LEN + 6, x, r, c, 0, 0};
        vecs[2] = '{2'b10, 32'h0, 4, 4, 5, 0, 0, 0,
                    0, 0, 1, 2 * LEN + 6, 0, 0, 4, 1024, 1024};
        vecs[3] = '{2'b10, 32'h0, 4, 4, 6, 0, 0, 0,
                    0, 0, 0, 2 * LEN + 6, 0, 0, 4, 18, 1024};
        vecs[4] = '{2'b11, 32'h1234_5678, 1, 2, 3, 0, 0, 0,
                    0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[5] = '{2'b10, sm, pk, rc, s, 0, 0, 0,
                    0, 0, 1, 2 * LEN + 6, 0, 0, c,
                    modpow(G, s, PM),
                    (modpow(pk, c, PM) * rc) % PM};

        do_reset();
        check("reset P_out", bus.P_out, 0);
        check("reset R_out", bus.R_out, 0);
        check("reset s_out", bus.s_out, 0);
        check("reset done", bus.done, 0);
        check("reset valid_gen", bus.valid_gen, 0);
        check("reset valid_sign", bus.valid_sign, 0);
        check("reset valid_ver", bus.valid_ver, 0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        check("keygen x const", x, 2);
        check("keygen P const", pk, 16);
        check("sign nonce const", r, 508);

        // Reset in the middle of the keygen exponentiation
        do_reset();
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        check("midexp priv_key", dut.priv_key, 2);
        check("midexp done", bus.done, 0);
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check("abort priv_key", dut.priv_key, 0);
        check("abort P_out", bus.P_out, 0);
        check("abort done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("abort stays idle", bus.done, 0);
        check("abort P_out idle", bus.P_out, 0);
        run_op(vecs[0], "rekey");

        // Start stays high after FIN with a new mode applied
        bus.mode = 2'b01;
        bus.msg  = 32'hDEAD_BEEF;
        repeat (40) @(negedge clk);
        check("held done", bus.done, 1);
        check("held P_out", bus.P_out, 16);
        check("held valid_gen", bus.valid_gen, 1);
        check("held valid_sign", bus.valid_sign, 0);
        check("held nonce", dut.nonce, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
